sobel_line_buffer: RTL

//  Upstream feeder for the Sobel-Feldman stage: turns a raster Y stream into the newest
//  3-row column (row y-1, y, y+1 at column x) per pixel, via two line RAMs.

---
 rtl/sobel_line_buffer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sobel_line_buffer.sv
// ---------------------------------------------------------------------------
// sobel_line_buffer
//   Feeds the Sobel-Feldman edge filter. It takes a raster luma stream and,
//   for every active pixel, produces the 3-row column at that x: the pixel
//   two lines back, the pixel one line back, and the incoming pixel. Two line
//   RAMs hold the older rows. Rows that do not exist yet at the top of a
//   frame are zero-padded. Fixed latency of 2 cycles from input to output.
//
// Ports
//   i_pclk         pixel clock, rising edge
//   i_arstn        asynchronous active-low reset
//   i_vs           one-cycle frame-start pulse
//   i_de           data enable, high while i_pixel is an active pixel
//   i_pixel        incoming luma (row y+1)
//   o_vs / o_de    i_vs / i_de delayed by 2 cycles
//   o_pixel_11_01  row y-1 pixel (two lines back), 0 when not yet buffered
//   o_pixel_00_01  row y pixel (one line back), 0 when not yet buffered
//   o_pixel_01_01  row y+1 pixel (the incoming one, delayed)
// ---------------------------------------------------------------------------
module sobel_line_buffer #(
  parameter int Y_DEPTH  = 8,
  parameter int H_ACTIVE = 640,
  parameter int ADDR_W   = 10
) (
  input  logic               i_pclk,
  input  logic               i_arstn,
  input  logic               i_vs,
  input  logic               i_de,
  input  logic [Y_DEPTH-1:0] i_pixel,
  output logic               o_vs,
  output logic               o_de,
  output logic [Y_DEPTH-1:0] o_pixel_11_01,
  output logic [Y_DEPTH-1:0] o_pixel_00_01,
  output logic [Y_DEPTH-1:0] o_pixel_01_01
);

  localparam logic [ADDR_W-1:0] LAST_X = ADDR_W'(H_ACTIVE - 1);

  // Column/row position of the current input pixel and the stream history
  logic [ADDR_W-1:0]  r_x;
  logic [1:0]         r_y;
  logic               r_de_prev;
  logic [ADDR_W-1:0]  cur_x;
  logic [1:0]         cur_y;
  logic [ADDR_W-1:0]  nxt_x;
  logic [1:0]         nxt_y;
  logic               de_fall;

  // Line RAMs and their registered read data
  logic [Y_DEPTH-1:0] ram0 [0:H_ACTIVE-1];
  logic [Y_DEPTH-1:0] ram1 [0:H_ACTIVE-1];
  logic [Y_DEPTH-1:0] rd0;
  logic [Y_DEPTH-1:0] rd1;

  // Stage-1 tag travelling alongside the RAM read
  logic               tag_de;
  logic               tag_vs;
  logic [Y_DEPTH-1:0] tag_pixel;
  logic [1:0]         tag_y;
  logic [ADDR_W-1:0]  tag_x;

  function automatic logic [1:0] sat_inc(input logic [1:0] y);
    return (y == 2'd2) ? 2'd2 : y + 2'd1;
  endfunction

  // Position bookkeeping. A frame start clears the counters before the
  // pixel arriving in the same cycle is placed, so that pixel is x=0, y=0.
  // A line that filled all H_ACTIVE columns has already advanced the row at
  // the wrap, which leaves r_x at 0; the following de falling edge must not
  // advance it a second time, so the falling edge only counts when r_x != 0.
  always_comb begin
    cur_x   = i_vs ? '0 : r_x;
    cur_y   = i_vs ? '0 : r_y;
    de_fall = r_de_prev & ~i_de;
    nxt_x   = r_x;
    nxt_y   = r_y;
    if (i_de) begin
      if (cur_x == LAST_X) begin
        nxt_x = '0;
        nxt_y = sat_inc(cur_y);
      end else begin
        nxt_x = cur_x + ADDR_W'(1);
        nxt_y = cur_y;
      end
    end else if (i_vs) begin
      nxt_x = '0;
      nxt_y = '0;
    end else if (de_fall) begin
      nxt_x = '0;
      if (r_x != '0) begin
        nxt_y = sat_inc(r_y);
      end
    end
  end

  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_x       <= '0;
      r_y       <= '0;
      r_de_prev <= 1'b0;
    end else begin
      r_x       <= nxt_x;
      r_y       <= nxt_y;
      r_de_prev <= i_de;
    end
  end

  // RAM writes. RAM0 takes the incoming row; one cycle later RAM1 takes
  // what RAM0 held at that column, so RAM1 always trails RAM0 by one line.
  // Contents are intentionally not reset; the row count masks stale data.
  always_ff @(posedge i_pclk) begin
    if (i_de) begin
      ram0[cur_x] <= i_pixel;
    end
    if (tag_de) begin
      ram1[tag_x] <= rd0;
    end
  end

  // Stage 1: synchronous reads (old data on same-address write) plus tag
  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      rd0       <= '0;
      rd1       <= '0;
      tag_de    <= 1'b0;
      tag_vs    <= 1'b0;
      tag_pixel <= '0;
      tag_y     <= '0;
      tag_x     <= '0;
    end else begin
      if (i_de) begin
        rd0 <= ram0[cur_x];
        rd1 <= ram1[cur_x];
      end
      tag_de    <= i_de;
      tag_vs    <= i_vs;
      tag_pixel <= i_pixel;
      tag_y     <= cur_y;
      tag_x     <= cur_x;
    end
  end

  // Stage 2: zero-pad rows not yet buffered and blank everything outside de
  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      o_vs          <= 1'b0;
      o_de          <= 1'b0;
      o_pixel_01_01 <= '0;
      o_pixel_00_01 <= '0;
      o_pixel_11_01 <= '0;
    end else begin
      o_vs          <= tag_vs;
      o_de          <= tag_de;
      o_pixel_01_01 <= tag_de ? tag_pixel : '0;
      o_pixel_00_01 <= (tag_de && tag_y >= 2'd1) ? rd0 : '0;
      o_pixel_11_01 <= (tag_de && tag_y >= 2'd2) ? rd1 : '0;
    end
  end

endmodule
